// File: rtl/wb_dma_pkg.sv
// Shared constants for the wb_dma block: cfg register map, CTRL bit positions
// and the copy-engine state encoding.
package wb_dma_pkg;

  // Register word index as decoded from cfg adr[3:2]
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_BUSY    = 1;
  localparam int unsigned CTRL_DONE    = 2;
  localparam int unsigned CTRL_ERR     = 3;
  localparam int unsigned CTRL_IRQ_ENA = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } dma_state_e;

endpackage

// File: rtl/wb_dma_if.sv
// 32-bit pipelined Wishbone B4 bundle used for both the cfg and dma ports.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, err, stall
  );
endinterface

// File: rtl/wb_dma_regs.sv
// Configuration register file behind the cfg Wishbone slave port.
// WB_DMA_IRQ_EN adds the CTRL IRQ_ENA bit and the registered irq output.
module wb_dma_regs
  import wb_dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_if.slave                  cfg,
  input  logic                 busy,
  input  logic                 set_done,
  input  logic                 set_err,
  output logic                 start,
  output logic [31:0]          src,
  output logic [31:0]          dst,
  output logic [LEN_WIDTH-1:0] len
`ifdef WB_DMA_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic        acc, wr, wr_ctrl;
  logic        done, err, irq_ena;
  logic [1:0]  idx;
  logic [31:0] rdata;
  logic        unused_ok;

  assign idx       = cfg.adr[3:2];
  assign acc       = cfg.cyc & cfg.stb;
  assign wr        = acc & cfg.we;
  assign wr_ctrl   = wr & (idx == REG_CTRL);
  assign start     = wr_ctrl & cfg.dat_m[CTRL_START] & ~busy;
  assign cfg.stall = 1'b0;
  assign cfg.err   = 1'b0;
  assign unused_ok = ^{cfg.sel, cfg.adr[31:4], cfg.adr[1:0]};

  always_comb begin
    rdata = '0;
    case (idx)
      REG_SRC: rdata = src;
      REG_DST: rdata = dst;
      REG_LEN: rdata = 32'(len);
      default: begin
        rdata[CTRL_BUSY]    = busy;
        rdata[CTRL_DONE]    = done;
        rdata[CTRL_ERR]     = err;
        rdata[CTRL_IRQ_ENA] = irq_ena;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cfg.ack   <= 1'b0;
      cfg.dat_s <= '0;
    end else begin
      cfg.ack <= acc;
      if (acc) cfg.dat_s <= rdata;
      if (wr && !busy) begin
        case (idx)
          REG_SRC: src <= {cfg.dat_m[31:2], 2'b00};
          REG_DST: dst <= {cfg.dat_m[31:2], 2'b00};
          REG_LEN: len <= cfg.dat_m[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (wr_ctrl && cfg.dat_m[CTRL_DONE]) done <= 1'b0;
      if (wr_ctrl && cfg.dat_m[CTRL_ERR])  err  <= 1'b0;
      // A zero-length start completes immediately without touching the bus
      if (start) begin
        done <= (len == '0);
        err  <= 1'b0;
      end
      if (set_done) done <= 1'b1;
      if (set_err)  err  <= 1'b1;
    end
  end

`ifdef WB_DMA_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_ena <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) irq_ena <= cfg.dat_m[CTRL_IRQ_ENA];
      irq <= irq_ena & (done | err);
    end
  end
`else
  assign irq_ena = 1'b0;
`endif

endmodule

// File: rtl/wb_dma.sv
// Single-channel word-copy DMA engine: cfg slave registers plus a dma master.
// WB_DMA_IRQ_EN adds the completion interrupt output irq.
module wb_dma
  import wb_dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  cfg,
  wb_if.master dma
`ifdef WB_DMA_IRQ_EN
  ,
  output logic irq
`endif
);

  dma_state_e           state, state_nx;
  logic [31:0]          src_r, dst_r, src_w, dst_w, data_q;
  logic [LEN_WIDTH-1:0] len_r, cnt;
  logic                 busy, start, set_done, set_err, xfer_ok;

  assign busy    = (state != IDLE);
  assign xfer_ok = dma.ack & ~dma.err;

  wb_dma_regs #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cfg),
    .busy     (busy),
    .set_done (set_done),
    .set_err  (set_err),
    .start    (start),
    .src      (src_r),
    .dst      (dst_r),
    .len      (len_r)
`ifdef WB_DMA_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      src_w  <= '0;
      dst_w  <= '0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          src_w <= src_r;
          dst_w <= dst_r;
          cnt   <= len_r;
        end
        RD_WAIT: if (xfer_ok) data_q <= dma.dat_s;
        WR_WAIT: if (xfer_ok) begin
          src_w <= src_w + 32'd4;
          dst_w <= dst_w + 32'd4;
          cnt   <= cnt - LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    set_done  = 1'b0;
    set_err   = 1'b0;
    dma.cyc   = 1'b0;
    dma.stb   = 1'b0;
    dma.we    = 1'b0;
    dma.sel   = 4'hF;
    dma.adr   = src_w;
    dma.dat_m = data_q;
    case (state)
      IDLE: if (start && len_r != '0) state_nx = RD_REQ;
      RD_REQ: begin
        dma.cyc = 1'b1;
        dma.stb = 1'b1;
        if (!dma.stall) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        // cyc drops in the read-terminating cycle so the write opens a fresh
        // bus cycle without spending an extra state per word
        dma.cyc = ~(dma.ack | dma.err);
        if (dma.err) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end else if (dma.ack) begin
          state_nx = WR_REQ;
        end
      end
      WR_REQ: begin
        dma.cyc = 1'b1;
        dma.stb = 1'b1;
        dma.we  = 1'b1;
        dma.adr = dst_w;
        if (!dma.stall) state_nx = WR_WAIT;
      end
      WR_WAIT: begin
        dma.cyc = 1'b1;
        dma.we  = 1'b1;
        dma.adr = dst_w;
        if (dma.err) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end else if (dma.ack) begin
          if (cnt == LEN_WIDTH'(1)) begin
            state_nx = IDLE;
            set_done = 1'b1;
          end else begin
            state_nx = RD_REQ;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_dma.sv
// Directed bench for wb_dma: RAM slave model on the dma port, write scoreboard,
// and cfg register accesses driven from a single stimulus sequence.
module tb_wb_dma;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_if cfg_bus();
  wb_if dma_bus();
`ifdef WB_DMA_IRQ_EN
  logic irq;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endfunction

`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp));

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;
  wr_t sb[$];

  logic [31:0] mem [0:255];
  int unsigned stall_left = 0;
  int unsigned wr_seen    = 0;
  int unsigned err_on_wr  = 0;

  int          cyc_count   = 0;
  int          first_rd    = -1;
  int          last_wr_ack = -1;
  int unsigned stall_seen  = 0;
  logic        cyc_seen    = 1'b0;
  logic        rd_since    = 1'b0;
  logic        gap_seen    = 1'b0;
  logic        prev_stall  = 1'b0;
  logic        prev_we     = 1'b0;
  logic [31:0] prev_adr    = '0;

  always #5 clk = ~clk;

  wb_dma #(
    .LEN_WIDTH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cfg (cfg_bus),
    .dma (dma_bus)
`ifdef WB_DMA_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  assign dma_bus.stall = dma_bus.cyc & dma_bus.stb & (stall_left != 0);

  always @(posedge clk) begin
    dma_bus.ack <= 1'b0;
    dma_bus.err <= 1'b0;
    if (dma_bus.cyc && dma_bus.stb) begin
      if (stall_left != 0) begin
        stall_left <= stall_left - 1;
      end else if (dma_bus.we) begin
        if (wr_seen + 1 == err_on_wr) begin
          dma_bus.err <= 1'b1;
        end else begin
          mem[dma_bus.adr[9:2]] <= dma_bus.dat_m;
          dma_bus.ack <= 1'b1;
        end
        wr_seen <= wr_seen + 1;
      end else begin
        dma_bus.dat_s <= mem[dma_bus.adr[9:2]];
        dma_bus.ack   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    cyc_count++;
    if (dma_bus.cyc) cyc_seen = 1'b1;
    if (prev_stall) begin
      n_checks++;
      if (dma_bus.stb !== 1'b1) begin
        n_fail++;
        $error("FAIL stall_stb: observed %0h, expected 1", dma_bus.stb);
      end
      n_checks++;
      if (dma_bus.adr !== prev_adr) begin
        n_fail++;
        $error("FAIL stall_adr: observed %0h, expected %0h", dma_bus.adr, prev_adr);
      end
      n_checks++;
      if (dma_bus.we !== prev_we) begin
        n_fail++;
        $error("FAIL stall_we: observed %0h, expected %0h", dma_bus.we, prev_we);
      end
    end
    prev_stall = dma_bus.cyc & dma_bus.stb & dma_bus.stall;
    prev_adr   = dma_bus.adr;
    prev_we    = dma_bus.we;
    if (prev_stall) stall_seen++;
    if (dma_bus.cyc && dma_bus.stb && !dma_bus.we) begin
      if (first_rd < 0) first_rd = cyc_count;
      rd_since = 1'b1;
      gap_seen = 1'b0;
    end
    if (!dma_bus.cyc) gap_seen = 1'b1;
    if (dma_bus.cyc && dma_bus.stb && dma_bus.we && !dma_bus.stall) begin
      if (rd_since) begin
        n_checks++;
        if (gap_seen !== 1'b1) begin
          n_fail++;
          $error("FAIL cyc_gap: no cyc gap between read and write");
        end
        rd_since = 1'b0;
      end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $error("FAIL sb_pending: unexpected write to %0h", dma_bus.adr);
      end else begin
        wr_t e;
        e = sb.pop_front();
        n_checks++;
        if (dma_bus.adr !== e.adr) begin
          n_fail++;
          $error("FAIL wr_adr: observed %0h, expected %0h", dma_bus.adr, e.adr);
        end
        n_checks++;
        if (dma_bus.dat_m !== e.dat) begin
          n_fail++;
          $error("FAIL wr_dat: observed %0h, expected %0h", dma_bus.dat_m, e.dat);
        end
      end
    end
    if (dma_bus.cyc && dma_bus.we && dma_bus.ack) last_wr_ack = cyc_count;
  end

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    cfg_bus.cyc   = 1'b1;
    cfg_bus.stb   = 1'b1;
    cfg_bus.we    = 1'b1;
    cfg_bus.adr   = {28'h0, a};
    cfg_bus.dat_m = v;
    @(negedge clk);
    cfg_bus.cyc = 1'b0;
    cfg_bus.stb = 1'b0;
    cfg_bus.we  = 1'b0;
    `CHK("cfg_wr_ack", cfg_bus.ack, 1'b1)
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    cfg_bus.cyc = 1'b1;
    cfg_bus.stb = 1'b1;
    cfg_bus.we  = 1'b0;
    cfg_bus.adr = {28'h0, a};
    @(negedge clk);
    cfg_bus.cyc = 1'b0;
    cfg_bus.stb = 1'b0;
    `CHK("cfg_rd_ack", cfg_bus.ack, 1'b1)
    d = cfg_bus.dat_s;
  endtask

  task automatic wait_bit(input int unsigned b, input string tag, output logic [31:0] d);
    d = '0;
    for (int i = 0; i < 100; i++) begin
      cfg_read(4'hC, d);
      if (d[b]) break;
    end
    `CHK(tag, d[b], 1'b1)
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    cfg_bus.cyc   = 1'b0;
    cfg_bus.stb   = 1'b0;
    cfg_bus.we    = 1'b0;
    cfg_bus.sel   = 4'hF;
    cfg_bus.adr   = '0;
    cfg_bus.dat_m = '0;
    for (int i = 0; i < 256; i++) mem[i] <= '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    `CHK("rst_cyc", dma_bus.cyc, 1'b0)
    `CHK("rst_stb", dma_bus.stb, 1'b0)
    `CHK("rst_we", dma_bus.we, 1'b0)
    `CHK("rst_cfg_ack", cfg_bus.ack, 1'b0)
`ifdef WB_DMA_IRQ_EN
    `CHK("rst_irq", irq, 1'b0)
`endif
    rst = 1'b0;
    cfg_read(4'h0, d); `CHK("rst_src", d, 32'h0)
    cfg_read(4'h4, d); `CHK("rst_dst", d, 32'h0)
    cfg_read(4'h8, d); `CHK("rst_len", d, 32'h0)
    cfg_read(4'hC, d); `CHK("rst_ctrl", d, 32'h0)

    for (int i = 0; i < 4; i++) mem[i] <= 32'(i + 1);
    cfg_write(4'h0, 32'h0);
    cfg_write(4'h4, 32'h103);
    cfg_read(4'h4, d); `CHK("dst_align", d, 32'h100)
    cfg_write(4'h8, 32'd4);
    for (int i = 0; i < 4; i++) sb.push_back('{adr: 32'h100 + 32'(4 * i), dat: 32'(i + 1)});
    first_rd    = -1;
    last_wr_ack = -1;
    cfg_write(4'hC, 32'h1);
    wait_bit(2, "copy_done", d);
    `CHK("copy_ctrl", d, 32'h4)
    `CHK("copy_cycles", last_wr_ack - first_rd + 1, 16)
    for (int i = 0; i < 4; i++) `CHK("copy_data", mem[64 + i], i + 1)
    `CHK("copy_sb_empty", sb.size(), 0)

    cfg_write(4'hC, 32'h4);
    cfg_read(4'hC, d); `CHK("w1c_done", d, 32'h0)
    cfg_write(4'h8, 32'd0);
    cyc_seen = 1'b0;
    cfg_write(4'hC, 32'h1);
    cfg_read(4'hC, d); `CHK("len0_done", d, 32'h4)
    `CHK("len0_no_cyc", cyc_seen, 1'b0)

    mem[4] <= 32'hA5A5_0001;
    mem[5] <= 32'hA5A5_0002;
    cfg_write(4'h0, 32'h10);
    cfg_write(4'h4, 32'h200);
    cfg_write(4'h8, 32'd2);
    sb.push_back('{adr: 32'h200, dat: 32'hA5A5_0001});
    sb.push_back('{adr: 32'h204, dat: 32'hA5A5_0002});
    stall_seen = 0;
    stall_left <= 3;
    cfg_write(4'hC, 32'h1);
    wait_bit(2, "stall_done", d);
    `CHK("stall_ctrl", d, 32'h4)
    `CHK("stall_count", stall_seen, 3)
    `CHK("stall_data0", mem[128], 32'hA5A5_0001)
    `CHK("stall_data1", mem[129], 32'hA5A5_0002)
    `CHK("stall_sb_empty", sb.size(), 0)

    for (int i = 0; i < 3; i++) mem[8 + i] <= 32'hC0DE_0000 + 32'(i);
    cfg_write(4'h0, 32'h20);
    cfg_write(4'h4, 32'h300);
    cfg_write(4'h8, 32'd3);
    sb.push_back('{adr: 32'h300, dat: 32'hC0DE_0000});
    sb.push_back('{adr: 32'h304, dat: 32'hC0DE_0001});
    wr_seen   <= 0;
    err_on_wr <= 2;
    cfg_write(4'hC, 32'h1);
    wait_bit(3, "err_seen", d);
    `CHK("err_ctrl", d, 32'h8)
    `CHK("err_cyc", dma_bus.cyc, 1'b0)
    `CHK("err_word0", mem[192], 32'hC0DE_0000)
    `CHK("err_word1", mem[193], 32'h0)
    `CHK("err_sb_empty", sb.size(), 0)
    err_on_wr <= 0;
    cfg_write(4'hC, 32'h8);
    cfg_read(4'hC, d); `CHK("w1c_err", d, 32'h0)

    for (int i = 0; i < 4; i++) mem[64 + i] <= '0;
    cfg_write(4'h0, 32'h0);
    cfg_write(4'h4, 32'h100);
    cfg_write(4'h8, 32'd2);
    sb.push_back('{adr: 32'h100, dat: 32'd1});
    sb.push_back('{adr: 32'h104, dat: 32'd2});
    cfg_write(4'hC, 32'h1);
    cfg_read(4'hC, d); `CHK("busy_ctrl", d, 32'h2)
    cfg_write(4'h8, 32'd9);
    cfg_write(4'h0, 32'h40);
    wait_bit(2, "busy_done", d);
    `CHK("busy_word0", mem[64], 32'd1)
    `CHK("busy_word1", mem[65], 32'd2)
    `CHK("busy_word2", mem[66], 32'd0)
    cfg_read(4'h8, d); `CHK("busy_len", d, 32'd2)
    cfg_read(4'h0, d); `CHK("busy_src", d, 32'h0)
    `CHK("busy_sb_empty", sb.size(), 0)

`ifdef WB_DMA_IRQ_EN
    cfg_write(4'hC, 32'h4);
    cfg_write(4'hC, 32'h10);
    cfg_read(4'hC, d); `CHK("irq_ena_rd", d, 32'h10)
    `CHK("irq_idle", irq, 1'b0)
    mem[12] <= 32'h1234_5678;
    cfg_write(4'h0, 32'h30);
    cfg_write(4'h4, 32'h380);
    cfg_write(4'h8, 32'd1);
    sb.push_back('{adr: 32'h380, dat: 32'h1234_5678});
    cfg_write(4'hC, 32'h11);
    `CHK("irq_busy", irq, 1'b0)
    wait_bit(2, "irq_done", d);
    `CHK("irq_ctrl", d, 32'h14)
    @(negedge clk);
    `CHK("irq_high", irq, 1'b1)
    `CHK("irq_data", mem[224], 32'h1234_5678)
    cfg_write(4'hC, 32'h14);
    @(negedge clk);
    `CHK("irq_low", irq, 1'b0)
`endif

    cfg_write(4'h0, 32'h0);
    cfg_write(4'h4, 32'h100);
    cfg_write(4'h8, 32'd4);
    cfg_write(4'hC, 32'h1);
    `CHK("pre_rst_stb", dma_bus.stb, 1'b1)
    rst = 1'b1;
    @(negedge clk);
    `CHK("rst_abort_cyc", dma_bus.cyc, 1'b0)
    rst = 1'b0;
    cyc_seen = 1'b0;
    repeat (10) @(negedge clk);
    `CHK("rst_quiet", cyc_seen, 1'b0)
    cfg_read(4'h8, d); `CHK("rst2_len", d, 32'h0)
    cfg_read(4'hC, d); `CHK("rst2_ctrl", d, 32'h0)
    `CHK("final_sb_empty", sb.size(), 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
